// File: rtl/mul_partial_product_combiner.sv
// rtl/mul_partial_product_combiner.sv - two-stage reducer of four 16x16 partial products into a 64-bit product
// Optional MUL_COMBINER_STATS_EN adds o_stat_ops, a count of completed output handshakes.
module mul_partial_product_combiner (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_in_p1,
  input  logic [31:0] i_in_p2,
  input  logic [31:0] i_in_p3,
  input  logic [31:0] i_in_p4,
  input  logic        i_in_src1_signed,
  input  logic        i_in_src2_signed,
  input  logic        i_in_sel_hi,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [63:0] o_out_product,
  output logic [31:0] o_out_result
`ifdef MUL_COMBINER_STATS_EN
  ,
  output logic [31:0] o_stat_ops
`endif
);

  logic        w_advance;
  logic [33:0] w_p2_ext;
  logic [33:0] w_p3_ext;
  logic [33:0] w_mid_sum;
  logic [63:0] w_mid_shift;
  logic [63:0] w_product;

  logic        r_s1_valid;
  logic [31:0] r_s1_p1;
  logic [31:0] r_s1_p4;
  logic [33:0] r_s1_mid;
  logic        r_s1_sel_hi;
  logic        r_out_valid;
  logic [63:0] r_out_product;
  logic [31:0] r_out_result;

  // Whole pipe stalls as one unit; the slot only frees when the output is empty or taken.
  assign w_advance  = ~r_out_valid | i_out_ready;
  assign o_in_ready = w_advance | i_reset;

  // Cross terms are summed at 34 bits so signed/unsigned mixes keep their true value.
  assign w_p2_ext  = {{2{i_in_src2_signed & i_in_p2[31]}}, i_in_p2};
  assign w_p3_ext  = {{2{i_in_src1_signed & i_in_p3[31]}}, i_in_p3};
  assign w_mid_sum = w_p2_ext + w_p3_ext;

  assign w_mid_shift = {{14{r_s1_mid[33]}}, r_s1_mid, 16'h0000};
  assign w_product   = {r_s1_p4, r_s1_p1} + w_mid_shift;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_valid    <= 1'b0;
      r_s1_p1       <= '0;
      r_s1_p4       <= '0;
      r_s1_mid      <= '0;
      r_s1_sel_hi   <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_product <= '0;
      r_out_result  <= '0;
    end else if (w_advance) begin
      r_s1_valid    <= i_in_valid;
      r_s1_p1       <= i_in_p1;
      r_s1_p4       <= i_in_p4;
      r_s1_mid      <= w_mid_sum;
      r_s1_sel_hi   <= i_in_sel_hi;
      r_out_valid   <= r_s1_valid;
      r_out_product <= w_product;
      r_out_result  <= r_s1_sel_hi ? w_product[63:32] : w_product[31:0];
    end
  end

  assign o_out_valid   = r_out_valid;
  assign o_out_product = r_out_product;
  assign o_out_result  = r_out_result;

`ifdef MUL_COMBINER_STATS_EN
  logic [31:0] r_stat_ops;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stat_ops <= '0;
    end else if (r_out_valid && i_out_ready) begin
      r_stat_ops <= r_stat_ops + 32'd1;
    end
  end

  assign o_stat_ops = r_stat_ops;
`endif

endmodule

// File: tb/tb_mul_partial_product_combiner.sv
// tb/tb_mul_partial_product_combiner.sv - randomized self-checking bench for mul_partial_product_combiner
module tb_mul_partial_product_combiner;

  typedef struct {
    logic [63:0] prod;
    logic [31:0] res;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_p1, in_p2, in_p3, in_p4;
  logic        in_src1_signed, in_src2_signed, in_sel_hi;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_product;
  logic [31:0] out_result;
`ifdef MUL_COMBINER_STATS_EN
  logic [31:0] stat_ops;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out    = 0;
  exp_t exp_q[$];
  exp_t pending;
  bit   last_in_fire = 0;
  bit   prev_stall   = 0;
  logic [63:0] held_prod;
  logic [31:0] held_res;

  mul_partial_product_combiner dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_in_valid       (in_valid),
    .o_in_ready       (in_ready),
    .i_in_p1          (in_p1),
    .i_in_p2          (in_p2),
    .i_in_p3          (in_p3),
    .i_in_p4          (in_p4),
    .i_in_src1_signed (in_src1_signed),
    .i_in_src2_signed (in_src2_signed),
    .i_in_sel_hi      (in_sel_hi),
    .o_out_valid      (out_valid),
    .i_out_ready      (out_ready),
    .o_out_product    (out_product),
    .o_out_result     (out_result)
`ifdef MUL_COMBINER_STATS_EN
    ,
    .o_stat_ops       (stat_ops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pp(logic [15:0] x, bit xs, logic [15:0] y, bit ys);
    longint xv, yv, r;
    xv = xs ? longint'($signed(x)) : longint'(x);
    yv = ys ? longint'($signed(y)) : longint'(y);
    r  = xv * yv;
    return r[31:0];
  endfunction

  task automatic set_raw(logic [31:0] p1, logic [31:0] p2, logic [31:0] p3, logic [31:0] p4,
                         bit s1, bit s2, bit sel, logic [63:0] prod);
    in_p1 = p1; in_p2 = p2; in_p3 = p3; in_p4 = p4;
    in_src1_signed = s1; in_src2_signed = s2; in_sel_hi = sel;
    in_valid = 1'b1;
    pending.prod = prod;
    pending.res  = sel ? prod[63:32] : prod[31:0];
  endtask

  task automatic set_ops(logic [31:0] a, logic [31:0] b, bit s1, bit s2, bit sel);
    longint av, bv, prod;
    av   = s1 ? longint'($signed(a)) : longint'(a);
    bv   = s2 ? longint'($signed(b)) : longint'(b);
    prod = av * bv;
    set_raw(pp(a[15:0], 1'b0, b[15:0], 1'b0), pp(a[15:0], 1'b0, b[31:16], s2),
            pp(a[31:16], s1, b[15:0], 1'b0), pp(a[31:16], s1, b[31:16], s2), s1, s2, sel, prod);
  endtask

  function automatic logic [31:0] rnd_operand();
    logic [31:0] r;
    case ($urandom_range(0, 7))
      0: r = 32'h0000_0000;
      1: r = 32'hFFFF_FFFF;
      2: r = 32'h8000_0000;
      3: r = 32'h7FFF_FFFF;
      4: r = 32'h0000_FFFF;
      default: r = $urandom;
    endcase
    return r;
  endfunction

  // Evaluates handshakes half a cycle before the edge, then advances one clock.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (reset) begin
      exp_q.delete();
      prev_stall   = 0;
      last_in_fire = 0;
    end else begin
      check("in_ready", in_ready, (!(out_valid && !out_ready)) ? 64'd1 : 64'd0);
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_product", out_product, held_prod);
        check("stall_result", out_result, held_res);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("product", out_product, e.prod);
          check("result", out_result, e.res);
          n_out++;
        end
      end
      last_in_fire = in_valid && in_ready;
      if (last_in_fire) exp_q.push_back(pending);
      prev_stall = out_valid && !out_ready;
      held_prod  = out_product;
      held_res   = out_result;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    guard     = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check("drain_timeout", 1, 0);
  endtask

  initial begin
    int sent, k, n0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_p1 = '0; in_p2 = '0; in_p3 = '0; in_p4 = '0;
    in_src1_signed = 1'b0; in_src2_signed = 1'b0; in_sel_hi = 1'b0;
    repeat (2) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_product", out_product, 0);
    check("rst_out_result", out_result, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef MUL_COMBINER_STATS_EN
    check("rst_stat_ops", stat_ops, 0);
`endif
    reset = 1'b0;
    out_ready = 1'b1;

    // Unsigned max*max, with two-cycle latency observed on the way out
    set_raw(32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 0, 0, 1, 64'hFFFFFFFE_00000001);
    tick();
    in_valid = 1'b0;
    check("latency_edge1", out_valid, 0);
    tick();
    check("latency_edge2", out_valid, 1);
    check("umax_result_hi", out_result, 32'hFFFFFFFE);
    drain();

    // Signed -1 * -1
    set_raw(32'hFFFE0001, 32'hFFFF0001, 32'hFFFF0001, 32'h00000001, 1, 1, 0, 64'd1);
    tick();
    drain();

    // Signed -2 * unsigned 3
    set_raw(32'h0002FFFA, 32'h00000000, 32'hFFFFFFFD, 32'h00000000, 1, 0, 0, 64'hFFFFFFFF_FFFFFFFA);
    tick();
    drain();

    // Back-to-back stream with a three-cycle downstream stall
    n0 = n_out; sent = 0; k = 0;
    while ((sent < 8 || exp_q.size() > 0) && k < 60) begin
      out_ready = !(k >= 3 && k <= 5);
      if (sent < 8) set_ops($urandom, $urandom, sent[0], sent[1], sent[2]);
      else in_valid = 1'b0;
      tick();
      if (last_in_fire) sent++;
      k++;
    end
    check("stream_count", n_out - n0, 8);

    // Reset with two products in flight
    out_ready = 1'b1;
    set_ops(32'd7, 32'd9, 0, 0, 0);
    tick();
    set_ops(32'd11, 32'd13, 0, 0, 0);
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("reset_mid_in_ready", in_ready, 1);
    tick();
    reset = 1'b0;
    check("reset_mid_out_valid", out_valid, 0);
    check("reset_mid_in_ready_after", in_ready, 1);
    tick();
    check("reset_mid_out_valid2", out_valid, 0);
    tick();
    check("reset_mid_out_valid3", out_valid, 0);
    set_ops(32'hFFFF_FFFF, 32'd2, 1, 0, 0);
    tick();
    drain();

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0)
        set_ops(rnd_operand(), rnd_operand(), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      else
        in_valid = 1'b0;
      tick();
    end
    drain();

`ifdef MUL_COMBINER_STATS_EN
    reset = 1'b1;
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_ops($urandom, $urandom, 0, 0, 0);
      tick();
    end
    drain();
    check("stat_ops_five", stat_ops, 5);
    force dut.r_stat_ops = 32'hFFFF_FFFF;
    #1;
    release dut.r_stat_ops;
    set_ops(32'd3, 32'd5, 0, 0, 0);
    tick();
    drain();
    check("stat_ops_wrap", stat_ops, 0);
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
